// File: rtl/exec_pkg.sv
// exec_pkg: opcode/funct encodings and MD-class decode shared by the execute stage.
package exec_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_ORI  = 6'h0d;
    localparam logic [5:0] OP_LUI  = 6'h0f;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2a;
    localparam logic [5:0] F_SLTU  = 6'h2b;

    typedef enum logic [2:0] {
        MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MF
    } md_op_e;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    function automatic md_op_e md_decode(input logic [5:0] op, input logic [5:0] fn);
        if (op != OP_R) return MD_NONE;
        case (fn)
            F_MULT:         return MD_MULT;
            F_MULTU:        return MD_MULTU;
            F_DIV:          return MD_DIV;
            F_DIVU:         return MD_DIVU;
            F_MTHI:         return MD_MTHI;
            F_MTLO:         return MD_MTLO;
            F_MFHI, F_MFLO: return MD_MF;
            default:        return MD_NONE;
        endcase
    endfunction

    function automatic logic is_md(input logic [5:0] op, input logic [5:0] fn);
        return md_decode(op, fn) != MD_NONE;
    endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit: HI/LO registers with a multi-cycle multiply/divide sequencer.
module md_unit
    import exec_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             acc_i,
    input  md_op_e           op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o
);

    md_state_e          state_q;
    logic [3:0]         cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q, ph_q, pl_q;
    logic               pwe_q;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH-1:0]   quot, rem;
    logic               msgn, dz;

    always_comb begin
        msgn  = op_i == MD_MULT;
        ext_a = {{WIDTH{msgn & a_i[WIDTH-1]}}, a_i};
        ext_b = {{WIDTH{msgn & b_i[WIDTH-1]}}, b_i};
        prod  = ext_a * ext_b;
        dz    = b_i == '0;
        quot  = dz ? '0 : op_i == MD_DIV ? WIDTH'($signed(a_i) / $signed(b_i)) : a_i / b_i;
        rem   = dz ? '0 : op_i == MD_DIV ? WIDTH'($signed(a_i) % $signed(b_i)) : a_i % b_i;
    end

    // Result is captured at acceptance and held until the countdown expires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ph_q    <= '0;
            pl_q    <= '0;
            pwe_q   <= 1'b0;
        end else if (state_q == MD_IDLE) begin
            if (acc_i && (op_i == MD_MULT || op_i == MD_MULTU)) begin
                state_q      <= MD_BUSY;
                cnt_q        <= 4'(MULT_CYC);
                {ph_q, pl_q} <= prod;
                pwe_q        <= 1'b1;
            end else if (acc_i && (op_i == MD_DIV || op_i == MD_DIVU)) begin
                state_q <= MD_BUSY;
                cnt_q   <= 4'(DIV_CYC);
                ph_q    <= rem;
                pl_q    <= quot;
                pwe_q   <= !dz;
            end else if (acc_i && op_i == MD_MTHI) begin
                hi_q <= a_i;
            end else if (acc_i && op_i == MD_MTLO) begin
                lo_q <= a_i;
            end
        end else if (cnt_q == 4'd1) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            pwe_q   <= 1'b0;
            if (pwe_q) begin
                hi_q <= ph_q;
                lo_q <= pl_q;
            end
        end else begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign busy_o = state_q == MD_BUSY;

endmodule

// File: rtl/exec_stage_md.sv
// exec_stage_md: execute stage with operand forwarding, ALU, E/M register and MD unit.
module exec_stage_md
    import exec_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               MULT_CYC = 5,
    parameter int               DIV_CYC  = 10,
    parameter logic [WIDTH-1:0] RESET_PC = 'h3000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    input  logic [31:0]      code,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [4:0]       rg_addr,
    input  logic [31:0]      rg_time,
    input  logic [4:0]       m_addr,
    input  logic [4:0]       w_addr,
    input  logic [WIDTH-1:0] m_data,
    input  logic [WIDTH-1:0] w_data,
    input  logic [31:0]      m_time,
    input  logic [31:0]      w_time,
    input  logic             flush,
    output logic [WIDTH-1:0] pc_q,
    output logic [31:0]      code_q,
    output logic [WIDTH-1:0] alu_q,
    output logic [WIDTH-1:0] st_q,
    output logic [4:0]       rg_addr_q,
    output logic [31:0]      rg_time_q,
    output logic             md_busy,
    output logic             stall
);

    logic [5:0]       op, fn;
    logic [4:0]       rs_a, rt_a;
    logic [15:0]      imm;
    logic [WIDTH-1:0] rs_fwd, rt_fwd, sext, zext, hi, lo, alu_d;
    logic             run_q, acc;

    function automatic logic [WIDTH-1:0] fwd(input logic [4:0] a, input logic [WIDTH-1:0] d);
        if (a != 5'd0 && m_time == '0 && m_addr == a) return m_data;
        if (a != 5'd0 && w_time == '0 && w_addr == a) return w_data;
        return d;
    endfunction

    assign op     = code[31:26];
    assign fn     = code[5:0];
    assign rs_a   = code[25:21];
    assign rt_a   = code[20:16];
    assign imm    = code[15:0];
    assign rs_fwd = fwd(rs_a, rs_data);
    assign rt_fwd = fwd(rt_a, rt_data);
    assign sext   = {{(WIDTH-16){imm[15]}}, imm};
    assign zext   = {{(WIDTH-16){1'b0}}, imm};
    assign stall  = md_busy && is_md(op, fn);
    assign acc    = run_q && !stall && !flush;

    always_comb begin
        alu_d = '0;
        if (op == OP_R) begin
            case (fn)
                F_ADD, F_ADDU: alu_d = rs_fwd + rt_fwd;
                F_SUB, F_SUBU: alu_d = rs_fwd - rt_fwd;
                F_AND:         alu_d = rs_fwd & rt_fwd;
                F_OR:          alu_d = rs_fwd | rt_fwd;
                F_SLT:         alu_d = {{(WIDTH-1){1'b0}}, $signed(rs_fwd) < $signed(rt_fwd)};
                F_SLTU:        alu_d = {{(WIDTH-1){1'b0}}, rs_fwd < rt_fwd};
                F_MFHI:        alu_d = hi;
                F_MFLO:        alu_d = lo;
                default:       alu_d = '0;
            endcase
        end else begin
            case (op)
                OP_ADDI:      alu_d = rs_fwd + sext;
                OP_ANDI:      alu_d = rs_fwd & zext;
                OP_ORI:       alu_d = rs_fwd | zext;
                OP_LUI:       alu_d = WIDTH'({imm, 16'h0000});
                OP_LW, OP_SW: alu_d = rs_fwd + sext;
                OP_JAL:       alu_d = pc + WIDTH'(8);
                default:      alu_d = '0;
            endcase
        end
    end

    // run_q holds the stage in reset state for the first edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q     <= 1'b0;
            pc_q      <= RESET_PC;
            code_q    <= '0;
            alu_q     <= '0;
            st_q      <= '0;
            rg_addr_q <= '0;
            rg_time_q <= '0;
        end else if (!run_q) begin
            run_q <= 1'b1;
        end else begin
            pc_q      <= pc;
            code_q    <= acc ? code : '0;
            alu_q     <= acc ? alu_d : '0;
            st_q      <= acc && op == OP_SW ? rt_fwd : '0;
            rg_addr_q <= acc ? rg_addr : '0;
            rg_time_q <= acc && rg_time != '0 ? rg_time - 32'd1 : '0;
        end
    end

    md_unit #(.WIDTH(WIDTH), .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) u_md (
        .clk   (clk),
        .reset (reset),
        .acc_i (acc),
        .op_i  (md_decode(op, fn)),
        .a_i   (rs_fwd),
        .b_i   (rt_fwd),
        .hi_o  (hi),
        .lo_o  (lo),
        .busy_o(md_busy)
    );

endmodule

// File: tb/tb_exec_stage_md.sv
// tb_exec_stage_md: directed self-checking bench for exec_stage_md.
module tb_exec_stage_md;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, code, rs_data, rt_data, rg_time, m_data, w_data, m_time, w_time;
    logic [4:0]  rg_addr, m_addr, w_addr;
    logic        flush;
    logic [31:0] pc_q, code_q, alu_q, st_q, rg_time_q;
    logic [4:0]  rg_addr_q;
    logic        md_busy, stall;
    int          n_chk = 0;
    int          n_fail = 0;

    exec_stage_md dut (
        .clk(clk), .reset(reset), .pc(pc), .code(code), .rs_data(rs_data), .rt_data(rt_data),
        .rg_addr(rg_addr), .rg_time(rg_time), .m_addr(m_addr), .w_addr(w_addr),
        .m_data(m_data), .w_data(w_data), .m_time(m_time), .w_time(w_time), .flush(flush),
        .pc_q(pc_q), .code_q(code_q), .alu_q(alu_q), .st_q(st_q), .rg_addr_q(rg_addr_q),
        .rg_time_q(rg_time_q), .md_busy(md_busy), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rt_op(input logic [4:0] rs, input logic [4:0] rt, input logic [5:0] fn);
        return {6'h00, rs, rt, 5'd1, 5'd0, fn};
    endfunction

    function automatic logic [31:0] it_op(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        code = 32'd0; rs_data = 32'd0; rt_data = 32'd0; rg_addr = 5'd0; rg_time = 32'd0;
        m_addr = 5'd0; w_addr = 5'd0; m_data = 32'd0; w_data = 32'd0;
        m_time = 32'd1; w_time = 32'd1; flush = 1'b0; pc = 32'h100;
    endtask

    task automatic exec1(input logic [31:0] c, input logic [31:0] a, input logic [31:0] b);
        code = c; rs_data = a; rt_data = b;
        step();
        code = 32'd0;
    endtask

    task automatic wait_idle(output int busy_cycles);
        busy_cycles = 0;
        while (md_busy && busy_cycles < 40) begin
            busy_cycles++;
            step();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #12;
        n_chk++; if (pc_q !== 32'h3000) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc_q, 32'h3000); end
        n_chk++; if ({code_q, alu_q, st_q, rg_time_q, rg_addr_q, md_busy} !== '0) begin n_fail++; $display("FAIL reset_outs got %h/%h/%h/%h/%h/%b want 0", code_q, alu_q, st_q, rg_time_q, rg_addr_q, md_busy); end
        @(negedge clk);
        reset = 1'b1;
        code = rt_op(5'd1, 5'd2, 6'h20); rs_data = 32'd4; rt_data = 32'd5; pc = 32'h200;
        step();
        n_chk++; if (code_q !== 32'd0 || pc_q !== 32'h3000) begin n_fail++; $display("FAIL release_edge got code %h pc %h want 0/3000", code_q, pc_q); end
        step();
        n_chk++; if (code_q !== rt_op(5'd1, 5'd2, 6'h20) || alu_q !== 32'd9 || pc_q !== 32'h200) begin n_fail++; $display("FAIL first_accept got %h/%h/%h want add/9/200", code_q, alu_q, pc_q); end
        idle_inputs();
    endtask

    task automatic test_forward();
        m_addr = 5'd5; m_time = 32'd0; m_data = 32'd7; w_addr = 5'd5; w_time = 32'd0; w_data = 32'd9;
        exec1(rt_op(5'd5, 5'd6, 6'h20), 32'd100, 32'd1);
        n_chk++; if (alu_q !== 32'd8) begin n_fail++; $display("FAIL fwd_m got %h want 8", alu_q); end
        m_time = 32'd2;
        exec1(rt_op(5'd5, 5'd6, 6'h20), 32'd100, 32'd1);
        n_chk++; if (alu_q !== 32'd10) begin n_fail++; $display("FAIL fwd_w got %h want a", alu_q); end
        m_addr = 5'd0; m_time = 32'd0; w_addr = 5'd0; w_time = 32'd0;
        exec1(rt_op(5'd0, 5'd6, 6'h20), 32'd100, 32'd1);
        n_chk++; if (alu_q !== 32'd101) begin n_fail++; $display("FAIL fwd_r0 got %h want 65", alu_q); end
        m_addr = 5'd6; w_addr = 5'd6;
        exec1(rt_op(5'd3, 5'd6, 6'h22), 32'd100, 32'd1);
        n_chk++; if (alu_q !== 32'd93) begin n_fail++; $display("FAIL fwd_rt got %h want 5d", alu_q); end
        idle_inputs();
        rg_addr = 5'd9; rg_time = 32'd3;
        exec1(rt_op(5'd1, 5'd2, 6'h21), 32'd1, 32'd1);
        n_chk++; if (rg_time_q !== 32'd2 || rg_addr_q !== 5'd9) begin n_fail++; $display("FAIL rg_time3 got %0d/%0d want 2/9", rg_time_q, rg_addr_q); end
        rg_time = 32'd0;
        exec1(rt_op(5'd1, 5'd2, 6'h21), 32'd1, 32'd1);
        n_chk++; if (rg_time_q !== 32'd0) begin n_fail++; $display("FAIL rg_time0 got %0d want 0", rg_time_q); end
        idle_inputs();
    endtask

    task automatic test_alu();
        logic [31:0] c [10];
        logic [31:0] a [10];
        logic [31:0] b [10];
        logic [31:0] e [10];
        c[0] = rt_op(5'd1, 5'd2, 6'h2a);        a[0] = 32'hFFFFFFFF; b[0] = 32'd1;        e[0] = 32'd1;
        c[1] = rt_op(5'd1, 5'd2, 6'h2b);        a[1] = 32'hFFFFFFFF; b[1] = 32'd1;        e[1] = 32'd0;
        c[2] = it_op(6'h0c, 5'd1, 5'd2, 16'h8000); a[2] = 32'hFFFFFFFF; b[2] = 32'd0;     e[2] = 32'h00008000;
        c[3] = it_op(6'h0d, 5'd1, 5'd2, 16'hF000); a[3] = 32'h00000001; b[3] = 32'd0;     e[3] = 32'h0000F001;
        c[4] = it_op(6'h0f, 5'd0, 5'd2, 16'h1234); a[4] = 32'd0;     b[4] = 32'd0;        e[4] = 32'h12340000;
        c[5] = it_op(6'h23, 5'd1, 5'd2, 16'hFFFC); a[5] = 32'h100;   b[5] = 32'd0;        e[5] = 32'h000000FC;
        c[6] = it_op(6'h08, 5'd1, 5'd2, 16'hFFFF); a[6] = 32'd0;     b[6] = 32'd0;        e[6] = 32'hFFFFFFFF;
        c[7] = it_op(6'h03, 5'd0, 5'd0, 16'h0010); a[7] = 32'd0;     b[7] = 32'd0;        e[7] = 32'h108;
        c[8] = rt_op(5'd1, 5'd2, 6'h24);        a[8] = 32'hF0F0F0F0; b[8] = 32'h0FF00FF0; e[8] = 32'h00F000F0;
        c[9] = rt_op(5'd1, 5'd2, 6'h20);        a[9] = 32'hFFFFFFFF; b[9] = 32'd2;        e[9] = 32'd1;
        for (int i = 0; i < 10; i++) begin
            exec1(c[i], a[i], b[i]);
            n_chk++; if (alu_q !== e[i]) begin n_fail++; $display("FAIL alu_%0d got %h want %h", i, alu_q, e[i]); end
            n_chk++; if (st_q !== 32'd0) begin n_fail++; $display("FAIL st_zero_%0d got %h want 0", i, st_q); end
        end
        exec1(it_op(6'h2b, 5'd1, 5'd2, 16'h0008), 32'h200, 32'hCAFE);
        n_chk++; if (alu_q !== 32'h208 || st_q !== 32'hCAFE) begin n_fail++; $display("FAIL sw got %h/%h want 208/cafe", alu_q, st_q); end
    endtask

    task automatic test_mult();
        int bc;
        int sc;
        exec1(rt_op(5'd1, 5'd2, 6'h18), 32'hFFFFFFFE, 32'd3);
        wait_idle(bc);
        n_chk++; if (bc !== 5) begin n_fail++; $display("FAIL mult_busy got %0d want 5", bc); end
        exec1(rt_op(5'd0, 5'd0, 6'h12), 32'd0, 32'd0);
        n_chk++; if (alu_q !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mflo got %h want fffffffa", alu_q); end
        exec1(rt_op(5'd0, 5'd0, 6'h10), 32'd0, 32'd0);
        n_chk++; if (alu_q !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mfhi got %h want ffffffff", alu_q); end
        exec1(rt_op(5'd1, 5'd2, 6'h19), 32'h80000000, 32'd4);
        code = rt_op(5'd0, 5'd0, 6'h10);
        sc = 0;
        while (stall && sc < 40) begin
            sc++;
            step();
            n_chk++; if (code_q !== 32'd0) begin n_fail++; $display("FAIL stall_bubble got %h want 0", code_q); end
        end
        n_chk++; if (sc !== 5) begin n_fail++; $display("FAIL stall_cycles got %0d want 5", sc); end
        step();
        code = 32'd0;
        n_chk++; if (alu_q !== 32'h00000002 || code_q !== rt_op(5'd0, 5'd0, 6'h10)) begin n_fail++; $display("FAIL multu_hi got %h want 2", alu_q); end
    endtask

    task automatic test_div();
        int bc;
        exec1(rt_op(5'd1, 5'd0, 6'h11), 32'h11, 32'd0);
        exec1(rt_op(5'd1, 5'd0, 6'h13), 32'h22, 32'd0);
        exec1(rt_op(5'd1, 5'd2, 6'h1b), 32'd7, 32'd0);
        wait_idle(bc);
        n_chk++; if (bc !== 10) begin n_fail++; $display("FAIL divz_busy got %0d want 10", bc); end
        exec1(rt_op(5'd0, 5'd0, 6'h10), 32'd0, 32'd0);
        n_chk++; if (alu_q !== 32'h11) begin n_fail++; $display("FAIL divz_hi got %h want 11", alu_q); end
        exec1(rt_op(5'd0, 5'd0, 6'h12), 32'd0, 32'd0);
        n_chk++; if (alu_q !== 32'h22) begin n_fail++; $display("FAIL divz_lo got %h want 22", alu_q); end
        exec1(rt_op(5'd1, 5'd2, 6'h1a), 32'hFFFFFFF9, 32'd2);
        wait_idle(bc);
        exec1(rt_op(5'd0, 5'd0, 6'h12), 32'd0, 32'd0);
        n_chk++; if (alu_q !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", alu_q); end
        exec1(rt_op(5'd0, 5'd0, 6'h10), 32'd0, 32'd0);
        n_chk++; if (alu_q !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", alu_q); end
        exec1(rt_op(5'd1, 5'd2, 6'h1b), 32'd7, 32'd2);
        wait_idle(bc);
        exec1(rt_op(5'd0, 5'd0, 6'h10), 32'd0, 32'd0);
        n_chk++; if (alu_q !== 32'd1) begin n_fail++; $display("FAIL divu_hi got %h want 1", alu_q); end
    endtask

    task automatic test_flush();
        flush = 1'b1; rg_addr = 5'd7; rg_time = 32'd3;
        exec1(it_op(6'h23, 5'd1, 5'd2, 16'h0004), 32'h100, 32'd0);
        n_chk++; if (code_q !== 32'd0 || rg_addr_q !== 5'd0 || rg_time_q !== 32'd0 || alu_q !== 32'd0) begin n_fail++; $display("FAIL flush_lw got %h/%0d/%0d/%h want 0", code_q, rg_addr_q, rg_time_q, alu_q); end
        exec1(rt_op(5'd1, 5'd2, 6'h18), 32'd2, 32'd3);
        n_chk++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL flush_md got busy %b want 0", md_busy); end
        flush = 1'b0; rg_addr = 5'd0; rg_time = 32'd0;
        exec1(rt_op(5'd1, 5'd2, 6'h18), 32'd2, 32'd3);
        flush = 1'b1;
        step(); step();
        n_chk++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL flush_keeps_busy got %b want 1", md_busy); end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bc;
        exec1(rt_op(5'd1, 5'd2, 6'h18), 32'd6, 32'd7);
        rg_addr = 5'd4; rg_time = 32'd5; pc = 32'h444;
        exec1(it_op(6'h0d, 5'd1, 5'd2, 16'h0055), 32'd0, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        n_chk++; if (pc_q !== 32'h3000 || md_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid got pc %h busy %b want 3000/0", pc_q, md_busy); end
        n_chk++; if ({code_q, alu_q, rg_addr_q, rg_time_q} !== '0) begin n_fail++; $display("FAIL rst_mid_outs got %h/%h/%0d/%0d want 0", code_q, alu_q, rg_addr_q, rg_time_q); end
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        step(); step();
        wait_idle(bc);
        exec1(rt_op(5'd0, 5'd0, 6'h12), 32'd0, 32'd0);
        n_chk++; if (alu_q !== 32'd0 || bc !== 0) begin n_fail++; $display("FAIL rst_discard got lo %h busy %0d want 0/0", alu_q, bc); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_alu();
        test_mult();
        test_div();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_stage_md.md
EXEC_STAGE_MD -- requirements
Module: exec_stage_md

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of pc, operands, results and HI/LO.
REQ-002 SHALL have parameter MULT_CYC, default 5, busy cycles for mult/multu, legal range 1..15.
REQ-003 SHALL have parameter DIV_CYC, default 10, busy cycles for div/divu, legal range 1..15.
REQ-004 SHALL have parameter RESET_PC, default 'h3000, reset value of pc_q.
REQ-005 SHALL have ports clk in 1 clock; reset in 1 asynchronous active-low reset.
REQ-006 SHALL have inputs pc, code, rs_data, rt_data (WIDTH/32/WIDTH/WIDTH), rg_addr 5, rg_time 32: stage D payload.
REQ-007 SHALL have inputs m_addr, w_addr 5; m_data, w_data WIDTH; m_time, w_time 32: M/W forwarding sources.
REQ-008 SHALL have input flush 1, which forces a bubble into the E/M register.
REQ-009 SHALL have outputs pc_q, code_q, alu_q, st_q (WIDTH/32/WIDTH/WIDTH), rg_addr_q 5, rg_time_q 32: E/M register.
REQ-010 SHALL have outputs md_busy 1 (multiply/divide in progress) and stall 1 (hold stage D this cycle, combinational).

Function
REQ-011 SHALL select rs_fwd = m_data if m_time==0, m_addr==rs and rs!=0; else w_data under the same test on W; else rs_data; rt likewise, M has priority.
REQ-012 SHALL on each non-stalled, non-flushed edge load pc_q<=pc, code_q<=code, rg_addr_q<=rg_addr, rg_time_q<=rg_time saturating-decremented (0 stays 0).
REQ-013 SHALL compute alu_q: add/addu/addi = sum; sub/subu = difference; and/or/andi/ori = bitwise, andi/ori zero-extended; slt signed, sltu unsigned, result 0/1; lui = imm<<16; lw/sw = rs+sign-extended imm; jal = pc+8; mfhi/mflo = HI/LO; all others 0.
REQ-014 SHALL load st_q<=rt_fwd for sw, otherwise 0.
REQ-015 SHALL truncate all arithmetic to WIDTH bits and raise no overflow trap.
REQ-016 SHALL run the MD FSM with states IDLE and BUSY: IDLE->BUSY on accepted mult/multu/div/divu, loading count with MULT_CYC or DIV_CYC; BUSY decrements each cycle; BUSY->IDLE when count reaches 0, committing the pending {HI,LO}.
REQ-017 SHALL compute the mult/multu result as a 2*WIDTH product (signed or unsigned), HI=upper and LO=lower; div/divu SHALL give LO=quotient and HI=remainder, signed truncating toward zero.
REQ-018 SHALL leave HI and LO unchanged on divide by zero, while still consuming DIV_CYC busy cycles.
REQ-019 SHALL write mthi/mtlo to HI/LO at the edge of acceptance.
REQ-020 SHALL drive md_busy=1 exactly while in BUSY.
REQ-021 SHALL assert stall when an MD-class op (mult, multu, div, divu, mfhi, mflo, mthi, mtlo) is in E and md_busy=1.
REQ-022 SHALL, while stall=1, load a bubble into E/M (code_q, alu_q, st_q, rg_addr_q, rg_time_q all 0; pc_q<=pc) and not start the MD unit.
REQ-023 SHALL on flush=1 load a bubble and not start the MD unit, with flush taking precedence over the instruction; an MD operation already in BUSY SHALL continue.
REQ-024 SHALL, when BUSY->IDLE and a new MD op arrive in the same cycle, keep stall=1 that cycle and accept the op on the next.

Reset
REQ-025 SHALL on reset low immediately set pc_q=RESET_PC, all other outputs 0, HI=LO=0, FSM IDLE with count 0, and discard any pending result.
REQ-026 SHALL release reset synchronously, with no instruction accepted on the release edge.

Structure
REQ-027 SHALL take opcode/funct constants and the MD-class decode function from shared package exec_pkg.
REQ-028 SHALL place HI/LO, the FSM and the counter in sub-module md_unit; forwarding, ALU and the E/M register SHALL stay top-level.

Verification
REQ-029 SHALL check forwarding: rs=5, m_addr=5, m_time=0, m_data=7, w_addr=5, w_data=9, add with rt_data=1 -> alu_q=8; with rs=0 -> no forwarding.
REQ-030 SHALL check mult: rs=-2, rt=3 -> md_busy for 5 cycles; then mflo -> 'hFFFFFFFA and mfhi -> 'hFFFFFFFF; mfhi issued while busy -> stall=1 for the remaining cycles.
REQ-031 SHALL check division: divu 7/0 -> HI/LO unchanged after 10 busy cycles; div -7/2 -> LO=-3, HI=-1.
REQ-032 SHALL check reset: assert reset mid-BUSY -> outputs clear that cycle, pc_q='h3000, md_busy=0.
REQ-033 SHALL check flush: flush with lw in E -> code_q=0, rg_addr_q=0; rg_time 3 -> 2, 0 -> 0.
